// File: rtl/stage_execute.sv
// Vector execute stage: lane-wise ALU with single-cycle ops and a
// multi-cycle shift-add multiplier, output registers held under stall.
module stage_execute #(
    parameter int vecSize      = 4,
    parameter int registerSize = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [2:0]                      opcode,
    input  logic [vecSize*registerSize-1:0] operandA,
    input  logic [vecSize*registerSize-1:0] operandB,
    input  logic [registerSize-1:0]         imm,
    input  logic                            useImm,
    input  logic                            writeEnableIn,
    input  logic                            writeMemFromIn,
    input  logic [1:0]                      writeRegFromIn,
    input  logic                            stall,
    input  logic                            flush,
    output logic [vecSize*registerSize-1:0] aluResult,
    output logic [registerSize-1:0]         alu_operand2,
    output logic [registerSize-1:0]         imm_out,
    output logic                            writeEnable,
    output logic                            writeMemFrom,
    output logic [1:0]                      writeRegFrom,
    output logic                            out_valid
);

    localparam int R  = registerSize;
    localparam int W  = vecSize * registerSize;
    localparam int SW = $clog2(registerSize);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLL = 3'd5;
    localparam logic [2:0] OP_SRL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {S_READY, S_MULT} state_t;

    // Writeback controls travelling with an instruction.
    typedef struct packed {
        logic [R-1:0] imm;
        logic [R-1:0] op2;
        logic         we;
        logic         wmf;
        logic [1:0]   wrf;
    } ctrl_t;

    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  mcand_q, mcand_d;
    logic [W-1:0]  mplier_q, mplier_d;
    ctrl_t         pend_q, pend_d;
    ctrl_t         outc_q, outc_d;
    logic [W-1:0]  res_q, res_d;
    logic          valid_q, valid_d;

    logic [W-1:0]  b_eff;
    logic [W-1:0]  alu_res;
    logic [W-1:0]  acc_step;
    ctrl_t         ctrl_in;
    logic          accept;
    logic          last_step;

    function automatic logic [R-1:0] lane_alu(input logic [2:0] op,
                                              input logic [R-1:0] a,
                                              input logic [R-1:0] b);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_SLL:  return a << b[SW-1:0];
            OP_SRL:  return a >> b[SW-1:0];
            default: return '0;  // MUL goes through the shift-add path
        endcase
    endfunction

    assign b_eff     = useImm ? {vecSize{imm}} : operandB;
    assign ctrl_in   = '{imm: imm, op2: b_eff[R-1:0], we: writeEnableIn,
                         wmf: writeMemFromIn, wrf: writeRegFromIn};
    assign in_ready  = (state_q == S_READY) && !stall && !flush && !reset;
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_q == SW'(R - 1));

    // Lane-wise single-cycle result and one shift-add step for every lane.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        alu_res  = '0;
        acc_step = '0;
        for (int l = 0; l < vecSize; l++) begin
            alu_res[l*R +: R]  = lane_alu(opcode, operandA[l*R +: R], b_eff[l*R +: R]);
            acc_step[l*R +: R] = acc_q[l*R +: R] + (mplier_q[l*R] ? mcand_q[l*R +: R] : '0);
        end
    end

    // Next-state logic: accept, multiply stepping, output load/hold, flush.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        pend_d   = pend_q;
        outc_d   = outc_q;
        res_d    = res_q;
        valid_d  = valid_q && stall;  // a valid result waits while writeback stalls

        if (flush) begin
            valid_d = 1'b0;
            state_d = S_READY;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_READY: begin
                    if (accept) begin
                        if (opcode == OP_MUL) begin
                            acc_d    = '0;
                            mcand_d  = operandA;
                            mplier_d = b_eff;
                            pend_d   = ctrl_in;
                            cnt_d    = '0;
                            state_d  = S_MULT;
                        end else begin
                            res_d   = alu_res;
                            outc_d  = ctrl_in;
                            valid_d = 1'b1;
                        end
                    end
                end
                S_MULT: begin
                    if (last_step) begin
                        // The final step is held off until writeback can take it.
                        if (!stall) begin
                            acc_d   = acc_step;
                            res_d   = acc_step;
                            outc_d  = pend_q;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                            state_d = S_READY;
                        end
                    end else begin
                        acc_d = acc_step;
                        for (int l = 0; l < vecSize; l++) begin
                            mcand_d[l*R +: R]  = mcand_q[l*R +: R] << 1;
                            mplier_d[l*R +: R] = mplier_q[l*R +: R] >> 1;
                        end
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_READY;
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_READY;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            pend_q   <= '0;
            outc_q   <= '0;
            res_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            pend_q   <= pend_d;
            outc_q   <= outc_d;
            res_q    <= res_d;
            valid_q  <= valid_d;
        end
    end

    assign aluResult    = res_q;
    assign alu_operand2 = outc_q.op2;
    assign imm_out      = outc_q.imm;
    assign writeEnable  = outc_q.we;
    assign writeMemFrom = outc_q.wmf;
    assign writeRegFrom = outc_q.wrf;
    assign out_valid    = valid_q;

endmodule
